// File: rtl/param_fifo.sv
// Synchronous FIFO with a registered read port, programmable almost-full and
// almost-empty thresholds, and sticky overflow/underflow flags.
module param_fifo #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_th,
  input  logic [ADDR_WIDTH:0]   ae_th,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wp_reg, wp_next;
  logic [ADDR_WIDTH-1:0] rp_reg, rp_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  valid_reg;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic                  push_acc, pop_acc;

  // A full FIFO still accepts a push when a pop frees a slot in the same
  // cycle; an empty FIFO never forwards a same-cycle push to the output.
  always_comb begin
    pop_acc  = pop && (count_reg != '0);
    push_acc = push && ((count_reg != FULL_COUNT) || pop_acc);

    wp_next = push_acc ? wp_reg + ADDR_WIDTH'(1) : wp_reg;
    rp_next = pop_acc  ? rp_reg + ADDR_WIDTH'(1) : rp_reg;

    count_next = count_reg;
    case ({push_acc, pop_acc})
      2'b10:   count_next = count_reg + (ADDR_WIDTH+1)'(1);
      2'b01:   count_next = count_reg - (ADDR_WIDTH+1)'(1);
      default: count_next = count_reg;
    endcase

    // A new error wins over a coincident clear.
    overflow_next  = (push && !push_acc) || (overflow_reg && !err_clr);
    underflow_next = (pop && !pop_acc) || (underflow_reg && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_reg        <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wp_reg        <= wp_next;
      rp_reg        <= rp_next;
      count_reg     <= count_next;
      valid_reg     <= pop_acc;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      if (pop_acc) begin
        data_out_reg <= mem[rp_reg];
      end
    end
  end

  // Storage array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && push_acc) begin
      mem[wp_reg] <= data_in;
    end
  end

  assign data_out     = data_out_reg;
  assign valid_out    = valid_reg;
  assign count        = count_reg;
  assign full         = (count_reg == FULL_COUNT);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= af_th);
  assign almost_empty = (count_reg <= ae_th);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;
  assign error        = overflow_reg || underflow_reg;

endmodule

// File: tb/tb_param_fifo.sv
// Scenario-driven bench for param_fifo: a queue model tracks accepted words,
// error flags and the expected read port; each test task checks the DUT against it.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [9:0] data_in = '0;
  logic [3:0] af_th = 4'd6;
  logic [3:0] ae_th = 4'd1;
  logic       err_clr = 1'b0;
  logic [9:0] data_out;
  logic       valid_out;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow, error;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [9:0] exp_q [$];
  logic [9:0] exp_data = '0;
  logic       exp_valid = 1'b0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;
  logic [3:0] exp_cnt;

  param_fifo #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .af_th(af_th), .ae_th(ae_th), .err_clr(err_clr),
    .data_out(data_out), .valid_out(valid_out), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .error(error)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and advance the model; outputs are sampled 1ns after the edge.
  task automatic step(input logic p, input logic q, input logic [9:0] d, input logic ec);
    logic pop_ok, push_ok;
    push = p; pop = q; data_in = d; err_clr = ec;
    pop_ok  = q && (exp_q.size() > 0);
    push_ok = p && ((exp_q.size() < 8) || pop_ok);
    exp_valid = pop_ok;
    if (pop_ok) exp_data = exp_q.pop_front();
    if (push_ok) exp_q.push_back(d);
    exp_ovf = (p && !push_ok) || (exp_ovf && !ec);
    exp_unf = (q && !pop_ok) || (exp_unf && !ec);
    exp_cnt = 4'(exp_q.size());
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset(input logic p, input logic [9:0] d);
    reset = 1'b0; push = p; pop = 1'b0; data_in = d; err_clr = 1'b0;
    exp_q.delete();
    exp_data = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0; exp_cnt = '0;
    @(posedge clk);
    #1;
    reset = 1'b1; push = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, '0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected empty=1 full=0", empty, full); end
    checks++; if (valid_out !== 1'b0 || data_out !== 10'h000) begin errors++; $display("FAIL reset_out: got valid=%b data=%h expected valid=0 data=000", valid_out, data_out); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 10'(i), 1'b0);
      checks++; if (count !== exp_cnt) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, exp_cnt); end
      checks++; if (almost_full !== (exp_cnt >= 4'd6) || almost_empty !== (exp_cnt <= 4'd1)) begin
        errors++; $display("FAIL fill_almost: got af=%b ae=%b expected af=%b ae=%b at count %0d", almost_full, almost_empty, exp_cnt >= 4'd6, exp_cnt <= 4'd1, exp_cnt);
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      checks++; if (valid_out !== 1'b1 || data_out !== exp_data) begin errors++; $display("FAIL drain_data: got valid=%b data=%h expected valid=1 data=%h", valid_out, data_out, exp_data); end
      checks++; if (count !== exp_cnt) begin errors++; $display("FAIL drain_count: got %0d expected %0d", count, exp_cnt); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++; if (valid_out !== 1'b0 || data_out !== exp_data) begin errors++; $display("FAIL idle_hold: got valid=%b data=%h expected valid=0 data=%h", valid_out, data_out, exp_data); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h100 + 10'(i), 1'b0);
    step(1'b1, 1'b0, 10'h3FF, 1'b0);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
    checks++; if (overflow !== exp_ovf || error !== 1'b1) begin errors++; $display("FAIL ovf_flag: got ovf=%b err=%b expected ovf=%b err=1", overflow, error, exp_ovf); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      checks++; if (data_out !== exp_data || data_out === 10'h3FF) begin errors++; $display("FAIL ovf_drain: got %h expected %h", data_out, exp_data); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (overflow !== exp_ovf || error !== (exp_ovf || exp_unf)) begin errors++; $display("FAIL ovf_clear: got ovf=%b err=%b expected ovf=%b err=%b", overflow, error, exp_ovf, exp_ovf || exp_unf); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (underflow !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL unf_flag: got unf=%b valid=%b expected unf=1 valid=0", underflow, valid_out); end
    checks++; if (data_out !== exp_data) begin errors++; $display("FAIL unf_hold: got %h expected %h", data_out, exp_data); end
    step(1'b1, 1'b1, 10'h055, 1'b0);
    checks++; if (count !== 4'd1 || valid_out !== 1'b0 || data_out !== exp_data) begin
      errors++; $display("FAIL unf_pushpop: got count=%0d valid=%b data=%h expected count=1 valid=0 data=%h", count, valid_out, data_out, exp_data);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (valid_out !== 1'b1 || data_out !== exp_data) begin errors++; $display("FAIL unf_nobypass: got valid=%b data=%h expected valid=1 data=%h", valid_out, data_out, exp_data); end
    step(1'b0, 1'b1, '0, 1'b1);
    checks++; if (underflow !== exp_unf) begin errors++; $display("FAIL unf_clr_vs_set: got %b expected %b", underflow, exp_unf); end
    step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (underflow !== exp_unf || error !== (exp_ovf || exp_unf)) begin errors++; $display("FAIL unf_clear: got unf=%b err=%b expected unf=%b err=%b", underflow, error, exp_unf, exp_ovf || exp_unf); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h200 + 10'(i), 1'b0);
    for (int i = 8; i < 28; i++) begin
      step(1'b1, 1'b1, 10'h200 + 10'(i), 1'b0);
      checks++; if (valid_out !== 1'b1 || data_out !== exp_data) begin errors++; $display("FAIL wrap_data: got valid=%b data=%h expected valid=1 data=%h", valid_out, data_out, exp_data); end
      checks++; if (count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL wrap_count: got count=%0d ovf=%b expected count=8 ovf=0", count, overflow); end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      checks++; if (data_out !== exp_data) begin errors++; $display("FAIL wrap_drain: got %h expected %h", data_out, exp_data); end
    end
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h0A0 + 10'(i), 1'b0);
    af_th = 4'd3; ae_th = 4'd2; #1;
    checks++; if (almost_full !== (exp_cnt >= af_th) || almost_empty !== (exp_cnt <= ae_th)) begin
      errors++; $display("FAIL th_edge: got af=%b ae=%b expected af=%b ae=%b", almost_full, almost_empty, exp_cnt >= af_th, exp_cnt <= ae_th);
    end
    af_th = 4'd15; ae_th = 4'd9; #1;
    checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin errors++; $display("FAIL th_over_depth: got af=%b ae=%b expected af=0 ae=1", almost_full, almost_empty); end
    af_th = 4'd6; ae_th = 4'd1; #1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 10'h0B0 + 10'(i), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL mid_precount: got %0d expected 4", count); end
    step(1'b1, 1'b0, 10'h0C0, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_count5: got %0d expected 5", count); end
    do_reset(1'b1, 10'h1EE);
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset: got count=%0d empty=%b expected count=0 empty=1", count, empty); end
    checks++; if (data_out !== 10'h000 || error !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got data=%h err=%b expected data=000 err=0", data_out, error); end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (underflow !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL mid_post_pop: got unf=%b valid=%b expected unf=1 valid=0", underflow, valid_out); end
  endtask

  initial begin
    exp_cnt = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_simul();
    test_thresholds();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
